// File: rtl/sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage.
// Fill phase stores incoming samples and replays the previous frame's differences.
// Butterfly phase emits the halved sums and stores the halved differences.
// All outputs are registered and feed a downstream 2-1 mux (sel=1 -> sum_out).
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module sdf_bf_stage #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] sum_out,
  output logic [DATA_WIDTH-1:0] fb_out,
  output logic                  sel,
  output logic                  out_valid
);

  localparam int HW = DATA_WIDTH / 2;
  // DEPTH is a power of two, so the 2*DEPTH counter wraps naturally.
  localparam int CW = $clog2(2 * DEPTH);

  logic [CW-1:0]         cnt;
  logic                  phase;
  logic                  primed;
  logic [DATA_WIDTH-1:0] dline [DEPTH];
  logic [DATA_WIDTH-1:0] tail;
  logic [DATA_WIDTH-1:0] bf_sum;
  logic [DATA_WIDTH-1:0] bf_diff;
  logic [DATA_WIDTH-1:0] shift_in;

  // Upper half of the frame is the butterfly phase.
  assign phase    = cnt[CW-1];
  assign tail     = dline[DEPTH-1];
  assign shift_in = phase ? bf_diff : in_data;

  // Per-component butterfly: HW+1 bit add/sub, then drop the LSB
  // (arithmetic shift right by one). HW+1 bits hold every result exactly,
  // so taking bits [HW:1] never overflows.
  for (genvar gi = 0; gi < 2; gi++) begin : g_comp
    logic signed [HW:0] a_ext;
    logic signed [HW:0] b_ext;
    logic signed [HW:0] s_full;
    logic signed [HW:0] d_full;

    assign a_ext  = {tail[gi*HW+HW-1], tail[gi*HW +: HW]};
    assign b_ext  = {in_data[gi*HW+HW-1], in_data[gi*HW +: HW]};
    assign s_full = a_ext + b_ext;
    assign d_full = a_ext - b_ext;
    assign bf_sum[gi*HW +: HW]  = s_full[HW:1];
    assign bf_diff[gi*HW +: HW] = d_full[HW:1];
  end

  // Delay line: shifts by one entry on every accepted sample.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dline
    if (gi == 0) begin : g_head
      // Head entry takes the raw sample (fill) or the halved difference (butterfly).
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        dline[0] <= '0;
        else if (in_valid) dline[0] <= shift_in;
      end
    end else begin : g_body
      // Remaining entries move one step toward the tail.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        dline[gi] <= '0;
        else if (in_valid) dline[gi] <= dline[gi-1];
      end
    end
  end

  // Frame position counter and primed flag; both hold while no sample arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      primed <= 1'b0;
    end else if (in_valid) begin
      cnt <= cnt + CW'(1);
      if (phase) primed <= 1'b1;
    end
  end

  // Registered outputs: data and sel update only on accepted samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_out   <= '0;
      fb_out    <= '0;
      sel       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // Before the first butterfly phase the fill outputs are only zeros.
      out_valid <= in_valid & (phase | primed);
      if (in_valid) begin
        if (phase) begin
          sum_out <= bf_sum;
          fb_out  <= '0;
          sel     <= 1'b1;
        end else begin
          sum_out <= '0;
          fb_out  <= tail;
          sel     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdf_bf_stage.sv
// Self-checking bench for sdf_bf_stage (DEPTH=4, 16-bit complex samples).
// A frame-level model checks every output on every cycle; directed
// scenarios also compare the captured mux stream against hand values.
module tb_sdf_bf_stage;

  localparam int DEPTH = 4;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] sum_out;
  logic [DW-1:0] fb_out;
  logic          sel;
  logic          out_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdf_bf_stage #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .sum_out(sum_out), .fb_out(fb_out), .sel(sel), .out_valid(out_valid)
  );

  // ---------------- frame-level reference model ----------------
  logic [DW-1:0] first_half [DEPTH];
  logic [DW-1:0] diffs [DEPTH];
  int            pos;
  bit            primed;
  logic [DW-1:0] exp_sum, exp_fb;
  logic          exp_sel, exp_valid;

  logic [16:0] out_q[$];
  logic [16:0] basic_q[$];
  bit          cap_en = 1'b0;

  // Complex (a+b)/2 or (a-b)/2 with floor rounding, computed on ints.
  function automatic logic [DW-1:0] half_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input bit sub);
    logic [DW-1:0] r;
    int ai, bi, ri;
    r = '0;
    for (int c = 0; c < 2; c++) begin
      ai = int'($signed(a[c*8 +: 8]));
      bi = int'($signed(b[c*8 +: 8]));
      ri = sub ? (ai - bi) : (ai + bi);
      ri = ri >>> 1;
      r[c*8 +: 8] = ri[7:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      first_half[i] = '0;
      diffs[i] = '0;
    end
    pos = 0; primed = 1'b0;
    exp_sum = '0; exp_fb = '0; exp_sel = 1'b0; exp_valid = 1'b0;
  endtask

  task automatic model_step(input logic [DW-1:0] x);
    exp_valid = (pos >= DEPTH) || primed;
    if (pos < DEPTH) begin
      exp_fb  = diffs[pos];
      exp_sum = '0;
      exp_sel = 1'b0;
      first_half[pos] = x;
    end else begin
      exp_sum = half_op(first_half[pos-DEPTH], x, 1'b0);
      diffs[pos-DEPTH] = half_op(first_half[pos-DEPTH], x, 1'b1);
      exp_fb  = '0;
      exp_sel = 1'b1;
      primed  = 1'b1;
    end
    pos = (pos + 1) % (2 * DEPTH);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n)        model_reset();
      else if (in_valid) model_step(in_data);
      else               exp_valid = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        check("sel", {31'b0, sel}, {31'b0, exp_sel});
        check("sum_out", {16'b0, sum_out}, {16'b0, exp_sum});
        check("fb_out", {16'b0, fb_out}, {16'b0, exp_fb});
        if (cap_en && out_valid) out_q.push_back({sel, sel ? sum_out : fb_out});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [DW-1:0] d);
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      in_valid = 1'b0;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_sum"}, {16'b0, sum_out}, 32'h0);
    check({tag, "_fb"}, {16'b0, fb_out}, 32'h0);
    check({tag, "_sel"}, {31'b0, sel}, 32'h0);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'h0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_zero_outputs(tag);
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  // Basic frame: re = 10..80, im = 0, then four zero samples; gap = idle cycles after each.
  task automatic basic_frame(input int gap, input int count);
    int v;
    for (int i = 0; i < count; i++) begin
      v = (i < 8) ? 10 * (i + 1) : 0;
      send({v[7:0], 8'h00});
      if (gap > 0) idle(gap);
    end
    idle(2);
  endtask

  task automatic check_basic_literals();
    int re_exp [8] = '{30, 40, 50, 60, -20, -20, -20, -20};
    int v;
    logic [16:0] w;
    check("basic_count", out_q.size(), 8);
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      v = re_exp[i];
      w = {(i < 4) ? 1'b1 : 1'b0, v[7:0], 8'h00};
      check($sformatf("basic_out%0d", i), {15'b0, out_q[i]}, {15'b0, w});
    end
  endtask

  task automatic compare_to_basic(input string tag);
    check({tag, "_count"}, out_q.size(), basic_q.size());
    for (int i = 0; i < out_q.size() && i < basic_q.size(); i++)
      check($sformatf("%s_out%0d", tag, i), {15'b0, out_q[i]}, {15'b0, basic_q[i]});
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int ar [16] = '{1, -1, 127, -128, 0, 0, 127, -128,
                    127, -128, 0, 0, -128, 127, 0, 0};
    int re_exp [16] = '{0, -1, 127, -128, 0, -1, 0, 0, -1, -1, 0, 0, 127, -128, 0, 0};
    int im_exp [16] = '{0, -1, 127, -128, -1, 0, 0, 0, -1, -1, 0, 0, -128, 127, 0, 0};
    int re_v, im_v, pe;
    logic [16:0] w;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Basic frame, continuous.
    out_q.delete(); cap_en = 1'b1;
    basic_frame(0, 12);
    cap_en = 1'b0;
    check_basic_literals();
    basic_q = out_q;

    // Rounding and extremes; im carries each pair swapped.
    do_reset("rst_round");
    out_q.delete(); cap_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pe = i % 8;
      re_v = ar[i];
      im_v = (pe < 4) ? ar[i+4] : ar[i-4];
      send({re_v[7:0], im_v[7:0]});
    end
    for (int i = 0; i < 4; i++) send(16'h0000);
    idle(2);
    cap_en = 1'b0;
    check("round_count", out_q.size(), 16);
    for (int i = 0; i < 16 && i < out_q.size(); i++) begin
      re_v = re_exp[i];
      im_v = im_exp[i];
      w = {((i % 8) < 4) ? 1'b1 : 1'b0, re_v[7:0], im_v[7:0]};
      check($sformatf("round_out%0d", i), {15'b0, out_q[i]}, {15'b0, w});
    end

    // Gapped input: pattern 1,0,0 covers the phase boundary and the wrap.
    do_reset("rst_gap");
    out_q.delete(); cap_en = 1'b1;
    basic_frame(2, 12);
    cap_en = 1'b0;
    compare_to_basic("gap");

    // Reset mid-operation, then replay.
    do_reset("rst_pre");
    for (int i = 0; i < 6; i++) send({8'(10 * (i + 1)), 8'h00});
    do_reset("rst_mid");
    out_q.delete(); cap_en = 1'b1;
    basic_frame(0, 12);
    cap_en = 1'b0;
    compare_to_basic("replay");

    // Continuous multi-frame random stream.
    do_reset("rst_rand");
    out_q.delete(); cap_en = 1'b1;
    for (int k = 0; k < 28; k++) begin
      send((k < 24) ? 16'($urandom()) : 16'h0000);
      // out_valid now reflects sample k-1
      if (k >= 5) check("stream_valid", {31'b0, out_valid}, 32'h1);
    end
    idle(2);
    cap_en = 1'b0;
    check("stream_count", out_q.size(), 24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdf_bf_stage.md
# sdf_bf_stage

Radix-2 single-path delay-feedback (SDF) butterfly stage for the streaming FFT datapath. It sits directly upstream of the 2-1 `Mux`. It produces the butterfly sum on `sum_out`, which drives the Mux `A_in`. It produces the delayed feedback difference on `fb_out`, which drives the Mux `B_in`. It generates the Mux `sel` so the Mux output is the stage's in-order output stream.

## Interface
- `DEPTH`, default 8. Feedback delay length; a power of 2, ≥1. The frame period is 2·DEPTH accepted samples.
- `DATA_WIDTH`, taken from `` `DATA_WIDTH ``. Must be even. Complex samples are packed {re, im}, each HW = `DATA_WIDTH`/2 bits, two's complement.
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` carries a sample this cycle.
- `in_data`  in  `DATA_WIDTH`  Input sample {re, im}.
- `sum_out`  out  `DATA_WIDTH`  Butterfly sum, to Mux `A_in`.
- `fb_out`  out  `DATA_WIDTH`  Feedback difference, to Mux `B_in`.
- `sel`  out  1  Mux select: 1 selects `sum_out`, 0 selects `fb_out`.
- `out_valid`  out  1  Mux output is a valid stage output this cycle.

## Operation
- State:
  - `cnt`: modulo 2·DEPTH counter of accepted samples.
  - phase = (`cnt` ≥ DEPTH).
  - DEPTH-entry delay line, where `tail` is the oldest entry.
  - `primed` flag.
- Accept: an input is accepted on every cycle with `in_valid`=1; there is no backpressure. With `in_valid`=0, the counter, delay line and `primed` hold, `out_valid`←0, and data outputs hold.
- Phase 0 (fill), on an accepted sample:
  - the delay line shifts in `in_data`;
  - `fb_out`←`tail`, `sum_out`←0, `sel`←0.
- Phase 1 (butterfly), on an accepted sample: a=`tail`, b=`in_data`.
  - `sum_out`←(a+b)>>>1 per component.
  - The delay line shifts in (a−b)>>>1 per component.
  - `fb_out`←0, `sel`←1, and `primed`←1.
- `out_valid`←`in_valid` & (phase 1 | `primed`). The first DEPTH outputs after reset are suppressed because they are zero-fill.
- Arithmetic, per component independently:
  - sign-extend to HW+1 bits;
  - add or subtract;
  - arithmetic shift right by 1 (truncation toward −∞);
  - keep the low HW bits.
  - This can never overflow. The re and im components never interact.
- No flush: the differences of the last frame emerge only while the next frame's first DEPTH samples stream in.
- `cnt` wraps from 2·DEPTH−1 to 0 with no idle cycle. Back-to-back frames are continuous.

## Timing
- All outputs are registered. Latency is 1 cycle from the accepting edge to `sum_out`/`fb_out`/`sel`/`out_valid`.
- The stage's sample order out of the Mux is: DEPTH sums (frame k, `sel`=1), then DEPTH differences of frame k (`sel`=0, during frame k+1 fill).
- Reset, asserted at any time including mid-frame, forces immediately:
  - `cnt`=0, delay line all 0, `primed`=0;
  - `sum_out`=0, `fb_out`=0, `sel`=0, `out_valid`=0.
- After `rst_n` deasserts, the first accepted sample is frame position 0.
- `in_valid` gaps of any length or position, including across the phase boundary and across the frame wrap, change only when outputs appear, never their values or order.

## Test plan
All scenarios use DEPTH=4 and `DATA_WIDTH`=16 (HW=8).
- **Basic frame.** Stimulus: re=10,20,30,40,50,60,70,80 with im=0, continuous, then re=0 ×4.
  - Cycles 5–8: `sum_out` re=30,40,50,60, `sel`=1, `out_valid`=1.
  - Next 4: `fb_out` re=−20 (0xEC) ×4, `sel`=0, `out_valid`=1.
  - The first 4 cycles show `out_valid`=0.
- **Rounding and extremes.** (a,b) pairs:
  - (1,0): sum 0.
  - (−1,0): sum −1, diff −1.
  - (127,127): sum 127, diff 0.
  - (−128,−128): sum −128.
  - (127,−128): diff 127.
  - (−128,127): diff −128.
  - All checked on re and im independently, with swapped values in im.
- **Gapped input.** Repeat the basic frame with `in_valid` pattern 1,0,0,1,… including a gap at `cnt`=3→4 and at the wrap. Required: identical output value sequence; `out_valid` only one cycle after accepted samples.
- **Reset mid-operation.** Assert `rst_n`=0 after 6 samples. Required: all outputs 0 immediately. Then replay the basic frame; required: results equal the fresh-reset case.
- **Continuous multi-frame.** Stream 3 frames of random data back-to-back. Compare Mux output (`sel` ? `sum_out` : `fb_out`) against a reference model. Required: `out_valid` stays 1 continuously after the first 4 samples.
